// File: rtl/fi_campaign_ctrl_if.sv
// Fault-injection port bundle between fi_campaign_ctrl and the aes_top / aes_top_ref pair.
// master = campaign controller, slave = the AES cores it drives and observes.
interface fi_campaign_ctrl_if;
  logic         ld;
  logic         en_FI;
  logic         mode_FI;
  logic [3:0]   func_FI;
  logic [3:0]   round_FI;
  logic [1:0]   row_FI;
  logic [1:0]   column_FI;
  logic [3:0]   bit_index_FI;
  logic         aes_done;
  logic [127:0] aes_text_out;
  logic         ref_done;
  logic [127:0] ref_text_out;
  logic         fault_detected;
  logic [4:0]   fault_location;

  modport master (
    output ld, en_FI, mode_FI, func_FI, round_FI, row_FI, column_FI, bit_index_FI,
    input  aes_done, aes_text_out, ref_done, ref_text_out, fault_detected, fault_location
  );

  modport slave (
    input  ld, en_FI, mode_FI, func_FI, round_FI, row_FI, column_FI, bit_index_FI,
    output aes_done, aes_text_out, ref_done, ref_text_out, fault_detected, fault_location
  );
endinterface

// File: rtl/fi_campaign_ctrl.sv
// Fault-injection campaign sequencer: sweeps round/row/column/bit on aes_top and classifies each point.
// Define FI_LOG_FIFO_EN to add an 8-entry log of silent-corruption coordinates.
module fi_campaign_ctrl #(
  parameter int ROUND_FIRST = 1,
  parameter int ROUND_LAST  = 9,
  parameter int TIMEOUT     = 63,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               cfg_mode,
  input  logic [3:0]         cfg_func,
  output logic               busy,
  output logic               camp_done,
  fi_campaign_ctrl_if.master fi,
  output logic [CNT_W-1:0]   n_inj,
  output logic [CNT_W-1:0]   n_detected,
  output logic [CNT_W-1:0]   n_silent,
  output logic [CNT_W-1:0]   n_masked,
  output logic [CNT_W-1:0]   n_loc_err,
  output logic [CNT_W-1:0]   n_timeout,
  output logic               log_valid,
  output logic [11:0]        log_data,
  input  logic               log_pop
);
  localparam int TW = $clog2(TIMEOUT + 1);

  // state   | meaning
  // S_IDLE  | waiting for start, counters hold last campaign
  // S_LOAD  | ld pulse for the current point, clear latches, arm timer
  // S_RUN   | wait for both cores (sticky latches) or timeout
  // S_CHECK | classify the point
  // S_NEXT  | advance the coordinate odometer
  // S_DONE  | camp_done pulse
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_CHECK, S_NEXT, S_DONE} state_t;
  state_t state, state_nx;

  logic          mode_q;
  logic [3:0]    func_q, round_q, bit_q;
  logic [1:0]    row_q, col_q;
  logic [TW-1:0] timer;
  logic          aes_seen, ref_seen, det_seen;
  logic [127:0]  aes_text_q, ref_text_q;
  logic          aes_now, ref_now, timeout_hit, texts_differ;
  logic          bit_wrap, col_wrap, row_wrap, all_wrap;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign aes_now      = aes_seen | fi.aes_done;
  assign ref_now      = ref_seen | fi.ref_done;
  assign texts_differ = (aes_text_q != ref_text_q);

  // Byte mode forces the bit digit to wrap every step, so only col/row/round advance.
  assign bit_wrap = mode_q | (bit_q == 4'd7);
  assign col_wrap = bit_wrap & (col_q == 2'd3);
  assign row_wrap = col_wrap & (row_q == 2'd3);
  assign all_wrap = row_wrap & (round_q == 4'(ROUND_LAST));

  always_comb begin
    state_nx    = state;
    timeout_hit = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nx = S_LOAD;
      S_LOAD:  state_nx = S_RUN;
      S_RUN: begin
        if (aes_now && ref_now) begin
          state_nx = S_CHECK;
        end else if (timer == '0) begin
          state_nx    = S_NEXT;
          timeout_hit = 1'b1;
        end
      end
      S_CHECK: state_nx = S_NEXT;
      S_NEXT:  state_nx = all_wrap ? S_DONE : S_LOAD;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      mode_q     <= 1'b0;
      func_q     <= '0;
      round_q    <= '0;
      row_q      <= '0;
      col_q      <= '0;
      bit_q      <= '0;
      timer      <= '0;
      aes_seen   <= 1'b0;
      ref_seen   <= 1'b0;
      det_seen   <= 1'b0;
      aes_text_q <= '0;
      ref_text_q <= '0;
      n_inj      <= '0;
      n_detected <= '0;
      n_silent   <= '0;
      n_masked   <= '0;
      n_loc_err  <= '0;
      n_timeout  <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_q     <= cfg_mode;
            func_q     <= cfg_func;
            round_q    <= 4'(ROUND_FIRST);
            row_q      <= '0;
            col_q      <= '0;
            bit_q      <= '0;
            n_inj      <= '0;
            n_detected <= '0;
            n_silent   <= '0;
            n_masked   <= '0;
            n_loc_err  <= '0;
            n_timeout  <= '0;
          end
        end
        S_LOAD: begin
          aes_seen <= 1'b0;
          ref_seen <= 1'b0;
          det_seen <= 1'b0;
          timer    <= TW'(TIMEOUT - 1);
        end
        S_RUN: begin
          if (fi.aes_done) aes_seen <= 1'b1;
          if (fi.ref_done) ref_seen <= 1'b1;
          if (fi.fault_detected) det_seen <= 1'b1;
          if (fi.aes_done && !aes_seen) aes_text_q <= fi.aes_text_out;
          if (fi.ref_done && !ref_seen) ref_text_q <= fi.ref_text_out;
          timer <= timer - TW'(1);
          if (timeout_hit) begin
            n_timeout <= sat_inc(n_timeout);
            n_inj     <= sat_inc(n_inj);
          end
        end
        S_CHECK: begin
          n_inj <= sat_inc(n_inj);
          if (det_seen) begin
            n_detected <= sat_inc(n_detected);
            if (fi.fault_location != ({1'b0, round_q} + 5'd1)) n_loc_err <= sat_inc(n_loc_err);
          end else if (texts_differ) begin
            n_silent <= sat_inc(n_silent);
          end else begin
            n_masked <= sat_inc(n_masked);
          end
        end
        S_NEXT: begin
          bit_q <= bit_wrap ? 4'd0 : bit_q + 4'd1;
          if (bit_wrap) col_q <= col_wrap ? 2'd0 : col_q + 2'd1;
          if (col_wrap) row_q <= row_wrap ? 2'd0 : row_q + 2'd1;
          if (row_wrap) round_q <= all_wrap ? 4'(ROUND_FIRST) : round_q + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign busy            = (state != S_IDLE);
  assign camp_done       = (state == S_DONE);
  assign fi.ld           = (state == S_LOAD);
  assign fi.en_FI        = (state == S_LOAD) || (state == S_RUN) || (state == S_CHECK) || (state == S_NEXT);
  assign fi.mode_FI      = mode_q;
  assign fi.func_FI      = func_q;
  assign fi.round_FI     = round_q;
  assign fi.row_FI       = row_q;
  assign fi.column_FI    = col_q;
  assign fi.bit_index_FI = bit_q;

`ifdef FI_LOG_FIFO_EN
  logic [11:0] fifo_mem [8];
  logic [2:0]  wr_ptr, rd_ptr;
  logic [3:0]  fifo_cnt;
  logic        log_push, do_push, do_pop;

  assign log_push = (state == S_CHECK) && !det_seen && texts_differ;
  assign do_pop   = log_pop && (fifo_cnt != 4'd0);
  assign do_push  = log_push && (fifo_cnt != 4'd8);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 3'd1;
      if (do_pop) rd_ptr <= rd_ptr + 3'd1;
      fifo_cnt <= fifo_cnt + {3'd0, do_push} - {3'd0, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) fifo_mem[wr_ptr] <= {round_q, row_q, col_q, bit_q};
  end

  assign log_valid = (fifo_cnt != 4'd0);
  assign log_data  = fifo_mem[rd_ptr];
`else
  logic unused_log_pop;
  assign unused_log_pop = log_pop;
  assign log_valid      = 1'b0;
  assign log_data       = '0;
`endif
endmodule

// File: tb/tb_fi_campaign_ctrl.sv
// Scoreboard bench for fi_campaign_ctrl: a behavioural aes_top/aes_top_ref responder plus a
// monitor that checks every ld point against queued coordinates and every campaign against queued stats.
module tb_fi_campaign_ctrl;
  localparam int RF = 1;
  localparam int RL = 2;
  localparam int TO = 63;
  localparam int CW = 16;

  typedef struct packed {
    logic [CW-1:0] inj, det, sil, msk, loc, tmo;
  } stats_t;

  logic          clk = 1'b0;
  logic          rst, start, cfg_mode, log_pop;
  logic [3:0]    cfg_func;
  logic          busy, camp_done, log_valid;
  logic [11:0]   log_data;
  logic [CW-1:0] n_inj, n_detected, n_silent, n_masked, n_loc_err, n_timeout;

  fi_campaign_ctrl_if ifc();

  fi_campaign_ctrl #(.ROUND_FIRST(RF), .ROUND_LAST(RL), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_mode(cfg_mode), .cfg_func(cfg_func),
    .busy(busy), .camp_done(camp_done), .fi(ifc),
    .n_inj(n_inj), .n_detected(n_detected), .n_silent(n_silent), .n_masked(n_masked),
    .n_loc_err(n_loc_err), .n_timeout(n_timeout),
    .log_valid(log_valid), .log_data(log_data), .log_pop(log_pop)
  );

  always #5 clk = ~clk;

  // responder knobs
  int           aes_lat = 2, ref_lat = 2;   // 0 = never
  logic [127:0] text_a = 128'h0123_4567_89ab_cdef_0011_2233_4455_6677;
  logic [127:0] text_b = 128'h0123_4567_89ab_cdef_0011_2233_4455_6678;
  logic         det_level = 1'b0;
  logic         loc_track = 1'b1;
  logic [4:0]   loc_const = 5'd0;

  assign ifc.fault_detected = det_level;
  assign ifc.fault_location = loc_track ? ({1'b0, ifc.round_FI} + 5'd1) : loc_const;

  // scoreboard
  logic [11:0] coord_q[$];
  stats_t      stats_q[$];
  logic        exp_mode;
  logic [3:0]  exp_func;
  int          exp_period = 0, last_ld = -1, ld_cnt = 0, done_cnt = 0, cyc = 0;
  int          n_chk = 0, n_fail = 0;
  logic        chk_idle_next = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic stats_t mk(input int inj, det, sil, msk, loc, tmo);
    stats_t s;
    s.inj = CW'(inj); s.det = CW'(det); s.sil = CW'(sil);
    s.msk = CW'(msk); s.loc = CW'(loc); s.tmo = CW'(tmo);
    return s;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // AES pair model: one-cycle done pulses a fixed latency after ld; text only valid with done
  initial begin
    int mx;
    ifc.aes_done = 1'b0; ifc.ref_done = 1'b0;
    ifc.aes_text_out = ~text_a; ifc.ref_text_out = text_b ^ 128'h1;
    forever begin
      @(negedge clk);
      if (ifc.ld === 1'b1) begin
        mx = (aes_lat > ref_lat) ? aes_lat : ref_lat;
        for (int k = 1; k <= mx; k++) begin
          @(negedge clk);
          ifc.aes_done     = (k == aes_lat);
          ifc.ref_done     = (k == ref_lat);
          ifc.aes_text_out = (k == aes_lat) ? text_a : ~text_a;
          ifc.ref_text_out = (k == ref_lat) ? text_b : (text_b ^ 128'h1);
        end
        @(negedge clk);
        ifc.aes_done = 1'b0; ifc.ref_done = 1'b0;
        ifc.aes_text_out = ~text_a; ifc.ref_text_out = text_b ^ 128'h1;
      end
    end
  end

  // monitor
  initial forever begin
    stats_t s;
    @(negedge clk);
    if (rst === 1'b0) begin
      if (chk_idle_next) begin
        check("busy_after_done", {31'd0, busy}, 32'd0);
        check("camp_done_width", {31'd0, camp_done}, 32'd0);
        chk_idle_next = 1'b0;
      end
      if (ifc.ld === 1'b1) begin
        ld_cnt++;
        check("en_FI_in_load", {31'd0, ifc.en_FI}, 32'd1);
        check("mode_FI", {31'd0, ifc.mode_FI}, {31'd0, exp_mode});
        check("func_FI", {28'd0, ifc.func_FI}, {28'd0, exp_func});
        if (coord_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL ld_unexpected: ld pulse with no point pending (t=%0t)", $time);
        end else begin
          check("coord", {20'd0, ifc.round_FI, ifc.row_FI, ifc.column_FI, ifc.bit_index_FI},
                {20'd0, coord_q.pop_front()});
        end
        if (exp_period != 0 && last_ld >= 0) check("ld_period", cyc - last_ld, exp_period);
        last_ld = cyc;
      end
      if (camp_done === 1'b1) begin
        done_cnt++;
        if (stats_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL camp_done_unexpected: pulse with no campaign pending (t=%0t)", $time);
        end else begin
          s = stats_q.pop_front();
          check("n_inj", n_inj, s.inj);
          check("n_detected", n_detected, s.det);
          check("n_silent", n_silent, s.sil);
          check("n_masked", n_masked, s.msk);
          check("n_loc_err", n_loc_err, s.loc);
          check("n_timeout", n_timeout, s.tmo);
          check("busy_in_done", {31'd0, busy}, 32'd1);
          check("en_FI_in_done", {31'd0, ifc.en_FI}, 32'd0);
          check("points_left", coord_q.size(), 32'd0);
        end
        chk_idle_next = 1'b1;
      end
    end
  end

  task automatic launch(input logic mode, input logic [3:0] func, input stats_t exp, input int period);
    int nb;
    nb = mode ? 1 : 8;
    for (int r = RF; r <= RL; r++)
      for (int row = 0; row < 4; row++)
        for (int col = 0; col < 4; col++)
          for (int b = 0; b < nb; b++)
            coord_q.push_back({4'(r), 2'(row), 2'(col), 4'(b)});
    stats_q.push_back(exp);
    exp_mode = mode; exp_func = func; exp_period = period; last_ld = -1; ld_cnt = 0;
    @(negedge clk);
    cfg_mode = mode; cfg_func = func; start = 1'b1;
    @(negedge clk);
    start = 1'b0; cfg_mode = ~mode; cfg_func = ~func;
  endtask

  task automatic wait_done(input string name);
    int t, d0;
    t = 0; d0 = done_cnt;
    while (done_cnt == d0 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (done_cnt == d0) begin
      n_chk++; n_fail++;
      $display("FAIL %s_timeout: no camp_done within %0d cycles", name, t);
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int t;
    rst = 1'b1; start = 1'b0; cfg_mode = 1'b0; cfg_func = 4'd0; log_pop = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_camp_done", {31'd0, camp_done}, 32'd0);
    check("rst_ld", {31'd0, ifc.ld}, 32'd0);
    check("rst_en_FI", {31'd0, ifc.en_FI}, 32'd0);
    check("rst_coord", {20'd0, ifc.round_FI, ifc.row_FI, ifc.column_FI, ifc.bit_index_FI}, 32'd0);
    check("rst_n_inj", n_inj, 32'd0);
    check("rst_log_valid", {31'd0, log_valid}, 32'd0);

    // bit mode, no detection, texts differ: every point silent
    aes_lat = 2; ref_lat = 1; det_level = 1'b0;
    launch(1'b0, 4'd1, mk(256, 0, 256, 0, 0, 0), 5);
    wait_done("bit_silent");
`ifdef FI_LOG_FIFO_EN
    for (int i = 0; i < 8; i++) begin
      check("log_valid_held", {31'd0, log_valid}, 32'd1);
      check("log_data", {20'd0, log_data}, 32'h100 + i);
      log_pop = 1'b1;
      @(negedge clk);
      log_pop = 1'b0;
    end
    check("log_empty_after_8", {31'd0, log_valid}, 32'd0);
`else
    log_pop = 1'b1;
    @(negedge clk);
    check("log_valid_off", {31'd0, log_valid}, 32'd0);
    check("log_data_off", {20'd0, log_data}, 32'd0);
    log_pop = 1'b0;
`endif

    // byte mode, CED always detects, location correct
    aes_lat = 3; ref_lat = 2; det_level = 1'b1; loc_track = 1'b1;
    launch(1'b1, 4'd0, mk(32, 32, 0, 0, 0, 0), 6);
    wait_done("byte_detect");

    // location stuck at 5: wrong for both rounds
    aes_lat = 1; ref_lat = 1; loc_track = 1'b0; loc_const = 5'd5;
    launch(1'b1, 4'd3, mk(32, 32, 0, 0, 32, 0), 4);
    wait_done("loc5");

    // location stuck at 2: right for round 1, wrong for round 2
    aes_lat = 2; ref_lat = 4; loc_const = 5'd2;
    launch(1'b1, 4'd2, mk(32, 32, 0, 0, 16, 0), 7);
    wait_done("loc2");

    // aes_done never arrives: every point times out after 63 RUN cycles
    aes_lat = 0; ref_lat = 2; det_level = 1'b1; loc_track = 1'b1;
    launch(1'b1, 4'd0, mk(32, 0, 0, 0, 0, 32), 1 + TO + 1);
    wait_done("timeout");

    // both done in the same cycle, equal texts: masked, CHECK right after; start while busy ignored
    aes_lat = 2; ref_lat = 2; det_level = 1'b0; text_b = text_a;
    launch(1'b1, 4'd1, mk(32, 0, 0, 32, 0, 0), 5);
    repeat (20) @(negedge clk);
    cfg_mode = 1'b0; cfg_func = 4'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0; cfg_mode = 1'b0; cfg_func = 4'd14;
    wait_done("masked");

    // reset during RUN of point 7, then restart from the first point
    aes_lat = 3; ref_lat = 3; det_level = 1'b1;
    launch(1'b1, 4'd0, mk(32, 32, 0, 0, 0, 0), 6);
    t = 0;
    while (ld_cnt < 7 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("reached_point7", ld_cnt >= 7, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_ld", {31'd0, ifc.ld}, 32'd0);
    check("abort_en_FI", {31'd0, ifc.en_FI}, 32'd0);
    check("abort_n_inj", n_inj, 32'd0);
    check("abort_n_detected", n_detected, 32'd0);
    check("abort_n_masked", n_masked, 32'd0);
    coord_q.delete();
    stats_q.delete();
    repeat (6) @(negedge clk);
    launch(1'b1, 4'd0, mk(32, 32, 0, 0, 0, 0), 6);
    wait_done("restart");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
